sprite_motion_controller: RTL
=============================

Name: sprite_motion_controller

Overview:
Player sprite controller, the parametrised successor of the per-frame player position updater. On each frame-tick pulse it runs a run/jump/crouch/halt state machine. Jumps follow real vertical physics: velocity, gravity, fast-fall and landing clamp. Run animation is divided down to a configurable rate. Outputs feed the sprite renderer as screen x/y plus ROM sprite id.

Parameters:
X_WIDTH, 9, width of signed xSprite
Y_WIDTH, 10, width of signed ySprite
ID_WIDTH, 4, width of spriteId
V_WIDTH, 6, width of signed internal vertical velocity
X_POS, 95, fixed horizontal sprite position
GROUND_Y, 200, ySprite when standing (screen y grows downward)
JUMP_VELOCITY, 12, initial upward velocity (pixels per tick)
GRAVITY, 1, velocity decrement per tick (doubled during fast-fall)
TERMINAL_VEL, 16, magnitude limit on downward velocity
RUN_FRAMES, 3, running animation ids 0..RUN_FRAMES-1
ANIM_DIV, 4, update ticks per running animation frame
JUMP_ID, 3, sprite id while airborne
CROUCH_ID, 4, sprite id while crouching
HALT_ID, 5, sprite id after collision

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
update  input  1  frame tick, single-cycle pulse; all state advances only on clock edges with update=1
keys  input  4  DE1 push-buttons, active-low; keys[0]=jump, keys[1]=crouch/fast-fall, keys[3:2] unused
collision  input  1  level, sampled on update ticks; forces HALT
xSprite  output  X_WIDTH  signed sprite x
ySprite  output  Y_WIDTH  signed sprite y
spriteId  output  ID_WIDTH  sprite ROM id
airborne  output  1  high while in JUMP

Behaviour:
- Reset (reset=0, asynchronous): state RUN, xSprite=X_POS, ySprite=GROUND_Y, spriteId=0, vel=0, anim divider=0, airborne=0, jump-key history=released (1).
- All outputs are registered. The effect of an update pulse is visible the cycle after that edge. With update=0 every register holds.
- Jump press = keys[0] low on this tick AND high on the previous tick. History is updated on every tick in every state. Holding the key never re-triggers a jump.
- RUN:
  - Divider counts 0..ANIM_DIV-1. On wrap, spriteId advances, wrapping RUN_FRAMES-1 -> 0.
  - Priority: collision > jump press > crouch held (keys[1]=0).
  - Jump press -> JUMP: vel=JUMP_VELOCITY, spriteId=JUMP_ID, airborne=1, y unchanged.
  - Crouch held -> CROUCH: spriteId=CROUCH_ID.
- JUMP, each tick:
  - next_y = ySprite - vel, computed at Y_WIDTH+1 bits.
  - g = 2*GRAVITY if keys[1]=0 (fast-fall), else GRAVITY.
  - vel = max(vel - g, -TERMINAL_VEL).
  - If next_y >= GROUND_Y: ySprite=GROUND_Y, vel=0, airborne=0, state RUN, spriteId=0, divider=0.
  - Otherwise ySprite=next_y.
  - The jump key is ignored while airborne.
- CROUCH:
  - keys[1]=1 -> RUN (spriteId=0, divider=0).
  - A jump press while crouching -> JUMP, taking priority over release.
- HALT: entered from any state when collision=1 on a tick. spriteId=HALT_ID, x/y frozen, airborne frozen. Exited only by reset.
- xSprite is constant X_POS in every state.
- Reset mid-jump returns immediately to the reset values above.

Test Plan:
- Reset: assert reset=0 mid-jump -> next cycle xSprite=95, ySprite=200, spriteId=0, airborne=0.
- Run animation (ANIM_DIV=4, RUN_FRAMES=3): 24 ticks, no keys -> spriteId sequence 0,1,2,0,1,2 with each value held 4 ticks; no change between ticks.
- Jump arc (JUMP_VELOCITY=4, GRAVITY=1, GROUND_Y=200):
  - Press keys[0] on tick 0, keep holding -> spriteId=3.
  - Following ticks give y = 196, 193, 191, 190, 190, 191, 193, 196, 200.
  - Landing on the 9th tick -> RUN, spriteId=0, airborne=0.
  - Holding keys[0] after landing does not rejump.
- Fast-fall: same jump with keys[1]=0 from the 5th airborne tick -> vel steps of 2, earlier landing clamped exactly at 200, never below.
- Crouch/priority: keys[0] and keys[1] fall on the same tick in RUN -> JUMP. Hold keys[1] alone -> spriteId=4. Release -> RUN, spriteId=0.
- Collision: collision=1 during JUMP at y=191 -> spriteId=5, y stays 191 for 10 further ticks regardless of keys. Reset recovers.

Source files
------------

// File: rtl/sprite_motion_controller.sv
// Player sprite controller: per-frame run/jump/crouch/halt state machine with
// vertical jump physics and divided-down run animation for the sprite renderer.
module sprite_motion_controller #(
   parameter int X_WIDTH       = 9,
   parameter int Y_WIDTH       = 10,
   parameter int ID_WIDTH      = 4,
   parameter int V_WIDTH       = 6,
   parameter int X_POS         = 95,
   parameter int GROUND_Y      = 200,
   parameter int JUMP_VELOCITY = 12,
   parameter int GRAVITY       = 1,
   parameter int TERMINAL_VEL  = 16,
   parameter int RUN_FRAMES    = 3,
   parameter int ANIM_DIV      = 4,
   parameter int JUMP_ID       = 3,
   parameter int CROUCH_ID     = 4,
   parameter int HALT_ID       = 5
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       update,
   input  logic [3:0]                 keys,
   input  logic                       collision,
   output logic signed [X_WIDTH-1:0]  xSprite,
   output logic signed [Y_WIDTH-1:0]  ySprite,
   output logic [ID_WIDTH-1:0]        spriteId,
   output logic                       airborne
);

   localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   localparam logic signed [X_WIDTH-1:0] X_INIT      = X_WIDTH'(X_POS);
   localparam logic signed [Y_WIDTH-1:0] GROUND_C    = Y_WIDTH'(GROUND_Y);
   localparam logic signed [Y_WIDTH:0]   GROUND_EXT  = (Y_WIDTH+1)'(GROUND_Y);
   localparam logic signed [V_WIDTH-1:0] JUMP_VEL_C  = V_WIDTH'(JUMP_VELOCITY);
   localparam logic signed [V_WIDTH:0]   GRAV1_C     = (V_WIDTH+1)'(GRAVITY);
   localparam logic signed [V_WIDTH:0]   GRAV2_C     = (V_WIDTH+1)'(2 * GRAVITY);
   localparam logic signed [V_WIDTH:0]   TERM_NEG_C  = (V_WIDTH+1)'(-TERMINAL_VEL);
   localparam logic [ID_WIDTH-1:0]       RUN_LAST_C  = ID_WIDTH'(RUN_FRAMES - 1);
   localparam logic [ID_WIDTH-1:0]       JUMP_ID_C   = ID_WIDTH'(JUMP_ID);
   localparam logic [ID_WIDTH-1:0]       CROUCH_ID_C = ID_WIDTH'(CROUCH_ID);
   localparam logic [ID_WIDTH-1:0]       HALT_ID_C   = ID_WIDTH'(HALT_ID);
   localparam logic [DIV_W-1:0]          DIV_LAST_C  = DIV_W'(ANIM_DIV - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_JUMP   = 2'd1,
      ST_CROUCH = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   state_t                     state_r;
   logic signed [V_WIDTH-1:0]  vel_r;
   logic [DIV_W-1:0]           div_r;
   logic                       jump_hist_r;

   logic                       jump_press_s;
   logic                       crouch_s;
   logic                       div_wrap_s;
   logic                       landed_s;
   logic signed [Y_WIDTH:0]    next_y_s;
   logic signed [V_WIDTH:0]    grav_s;
   logic signed [V_WIDTH:0]    vel_dec_s;
   logic signed [V_WIDTH:0]    vel_clamp_s;
   logic                       unused_keys_s;

   assign unused_keys_s = ^keys[3:2];

   // Edge detect on the jump key and one step of vertical physics, all one bit wider than the state.
   always_comb begin
      jump_press_s = ~keys[0] & jump_hist_r;
      crouch_s     = ~keys[1];
      div_wrap_s   = (div_r == DIV_LAST_C);
      next_y_s     = {ySprite[Y_WIDTH-1], ySprite}
                   - {{(Y_WIDTH+1-V_WIDTH){vel_r[V_WIDTH-1]}}, vel_r};
      landed_s     = (next_y_s >= GROUND_EXT);
      if (crouch_s) begin
         grav_s = GRAV2_C;
      end else begin
         grav_s = GRAV1_C;
      end
      vel_dec_s = {vel_r[V_WIDTH-1], vel_r} - grav_s;
      if (vel_dec_s < TERM_NEG_C) begin
         vel_clamp_s = TERM_NEG_C;
      end else begin
         vel_clamp_s = vel_dec_s;
      end
   end

   // Movement state machine; every register advances only on update ticks.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_RUN;
         xSprite     <= X_INIT;
         ySprite     <= GROUND_C;
         spriteId    <= '0;
         vel_r       <= '0;
         div_r       <= '0;
         airborne    <= 1'b0;
         jump_hist_r <= 1'b1;
      end else if (update) begin
         jump_hist_r <= keys[0];
         xSprite     <= X_INIT;
         case (state_r)
            ST_RUN: begin
               if (collision) begin
                  state_r  <= ST_HALT;
                  spriteId <= HALT_ID_C;
               end else if (jump_press_s) begin
                  state_r  <= ST_JUMP;
                  vel_r    <= JUMP_VEL_C;
                  spriteId <= JUMP_ID_C;
                  airborne <= 1'b1;
               end else if (crouch_s) begin
                  state_r  <= ST_CROUCH;
                  spriteId <= CROUCH_ID_C;
               end else if (div_wrap_s) begin
                  div_r <= '0;
                  if (spriteId >= RUN_LAST_C) begin
                     spriteId <= '0;
                  end else begin
                     spriteId <= spriteId + {{(ID_WIDTH-1){1'b0}}, 1'b1};
                  end
               end else begin
                  div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
               end
            end
            ST_JUMP: begin
               if (collision) begin
                  state_r  <= ST_HALT;
                  spriteId <= HALT_ID_C;
               end else if (landed_s) begin
                  state_r  <= ST_RUN;
                  ySprite  <= GROUND_C;
                  vel_r    <= '0;
                  airborne <= 1'b0;
                  spriteId <= '0;
                  div_r    <= '0;
               end else begin
                  ySprite <= next_y_s[Y_WIDTH-1:0];
                  vel_r   <= vel_clamp_s[V_WIDTH-1:0];
               end
            end
            ST_CROUCH: begin
               if (collision) begin
                  state_r  <= ST_HALT;
                  spriteId <= HALT_ID_C;
               end else if (jump_press_s) begin
                  state_r  <= ST_JUMP;
                  vel_r    <= JUMP_VEL_C;
                  spriteId <= JUMP_ID_C;
                  airborne <= 1'b1;
               end else if (!crouch_s) begin
                  state_r  <= ST_RUN;
                  spriteId <= '0;
                  div_r    <= '0;
               end else begin
                  state_r <= ST_CROUCH;
               end
            end
            ST_HALT: begin
               state_r <= ST_HALT;
            end
            default: begin
               state_r <= ST_RUN;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

endmodule
